// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Definitions shared across the CNN datapath blocks:
//   CNN_DATA_W      default datapath width (signed two's-complement fixed point)
//   ofmbuf_state_e  sequencer states of the output feature-map buffer
// -----------------------------------------------------------------------------
package cnn_pkg;

  localparam int CNN_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } ofmbuf_state_e;

endpackage : cnn_pkg

// File: rtl/output_fm_buffer_tile_counter.sv
// -----------------------------------------------------------------------------
// tile_counter
// Nested row/col/pass wrap counter walking a ROWS_p x COLS_p tile in row-major
// order, repeated num_pass_i times. Column is the fastest-moving index.
//   clk_i, rst_n_i  clock, asynchronous active-low reset
//   clr_i           synchronous clear of all three indices (wins over en_i)
//   en_i            advance by one location
//   num_pass_i      number of passes (caller guarantees >= 1)
//   row_o/col_o     current location
//   pass_o          current pass index
//   last_o          current location is the last col, last row and last pass
// -----------------------------------------------------------------------------
module tile_counter #(
  parameter int ROWS_p   = 4,
  parameter int COLS_p   = 4,
  parameter int PASS_W_p = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      clr_i,
  input  logic                      en_i,
  input  logic [PASS_W_p-1:0]       num_pass_i,
  output logic [$clog2(ROWS_p)-1:0] row_o,
  output logic [$clog2(COLS_p)-1:0] col_o,
  output logic [PASS_W_p-1:0]       pass_o,
  output logic                      last_o
);

  localparam int ROW_W = $clog2(ROWS_p);
  localparam int COL_W = $clog2(COLS_p);

  logic [ROW_W-1:0]    row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [PASS_W_p-1:0] pass_q, pass_d;
  logic                last_row_s, last_col_s, last_pass_s;

  assign last_col_s  = (col_q == COL_W'(COLS_p - 1));
  assign last_row_s  = (row_q == ROW_W'(ROWS_p - 1));
  assign last_pass_s = (pass_q == (num_pass_i - PASS_W_p'(1)));

  // next-index computation: col wraps into row, row wraps into pass
  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    pass_d = pass_q;
    if (clr_i) begin
      row_d  = {ROW_W{1'b0}};
      col_d  = {COL_W{1'b0}};
      pass_d = {PASS_W_p{1'b0}};
    end else if (en_i) begin
      if (last_col_s) begin
        col_d = {COL_W{1'b0}};
        if (last_row_s) begin
          row_d = {ROW_W{1'b0}};
          // wrapping the final pass leaves the counter parked at zero
          if (last_pass_s) begin
            pass_d = {PASS_W_p{1'b0}};
          end else begin
            pass_d = pass_q + PASS_W_p'(1);
          end
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end else begin
      row_d  = row_q;
      col_d  = col_q;
      pass_d = pass_q;
    end
  end

  // index registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      row_q  <= {ROW_W{1'b0}};
      col_q  <= {COL_W{1'b0}};
      pass_q <= {PASS_W_p{1'b0}};
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      pass_q <= pass_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign pass_o = pass_q;
  assign last_o = last_col_s && last_row_s && last_pass_s;

endmodule : tile_counter

// File: rtl/output_fm_buffer.sv
// -----------------------------------------------------------------------------
// output_fm_buffer
// Holds one Tr_p x Tc_p output-feature-map tile of partial sums. During ACCUM it
// presents the running partial sum of (row_o, col_o) on fm_init_o and stores
// the MAC result fm_i back, for num_pass_i passes. It then drains the tile
// row-major on a valid/ready stream and pulses done_o.
// Optional build macro: OFMBUF_RELU_EN -- drained words with MSB set are
// replaced by zero (stored values and fm_init_o untouched).
// Ports:
//   clk_i, rst_n_i           clock, asynchronous active-low reset
//   start_i, num_pass_i      tile start and pass count (0 acts as 1), IDLE only
//   busy_o, done_o           ACCUM/DRAIN indicator, end-of-tile pulse
//   row_o, col_o, pass_o     current accumulation location and pass
//   fm_init_o                partial sum for the current location
//   mac_valid_i, fm_i        MAC result for the current location
//   out_valid_o, out_ready_i drain handshake
//   out_data_o, out_last_o   drained element, last-element flag
// -----------------------------------------------------------------------------
module output_fm_buffer
  import cnn_pkg::*;
#(
  parameter int Tr_p     = 4,
  parameter int Tc_p     = 4,
  parameter int DATA_W_p = CNN_DATA_W,
  parameter int PASS_W_p = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    start_i,
  input  logic [PASS_W_p-1:0]     num_pass_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [$clog2(Tr_p)-1:0] row_o,
  output logic [$clog2(Tc_p)-1:0] col_o,
  output logic [PASS_W_p-1:0]     pass_o,
  output logic [DATA_W_p-1:0]     fm_init_o,
  input  logic                    mac_valid_i,
  input  logic [DATA_W_p-1:0]     fm_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [DATA_W_p-1:0]     out_data_o,
  output logic                    out_last_o
);

  localparam int ROW_W = $clog2(Tr_p);
  localparam int COL_W = $clog2(Tc_p);

  ofmbuf_state_e       state_q, state_d;
  logic [PASS_W_p-1:0] npass_q, npass_d;
  logic                done_q, done_d;
  logic [DATA_W_p-1:0] mem_q [Tr_p][Tc_p];

  logic                acc_clr_s, acc_en_s, acc_last_s;
  logic [ROW_W-1:0]    acc_row_s;
  logic [COL_W-1:0]    acc_col_s;
  logic [PASS_W_p-1:0] acc_pass_s;

  logic                drain_clr_s, drain_en_s, drain_last_s;
  logic [ROW_W-1:0]    drain_row_s;
  logic [COL_W-1:0]    drain_col_s;
  logic [PASS_W_p-1:0] drain_pass_unused_s;
  logic [DATA_W_p-1:0] drain_raw_s, drain_word_s;

  assign acc_clr_s   = (state_q == ST_IDLE) && start_i;
  assign acc_en_s    = (state_q == ST_ACCUM) && mac_valid_i;
  assign drain_clr_s = acc_en_s && acc_last_s;
  assign drain_en_s  = (state_q == ST_DRAIN) && out_ready_i;

  tile_counter #(.ROWS_p(Tr_p), .COLS_p(Tc_p), .PASS_W_p(PASS_W_p)) u_acc_cnt (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .clr_i      (acc_clr_s),
    .en_i       (acc_en_s),
    .num_pass_i (npass_q),
    .row_o      (acc_row_s),
    .col_o      (acc_col_s),
    .pass_o     (acc_pass_s),
    .last_o     (acc_last_s)
  );

  // the drain walk is a single pass, so its pass index is always zero
  tile_counter #(.ROWS_p(Tr_p), .COLS_p(Tc_p), .PASS_W_p(PASS_W_p)) u_drain_cnt (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .clr_i      (drain_clr_s),
    .en_i       (drain_en_s),
    .num_pass_i (PASS_W_p'(1)),
    .row_o      (drain_row_s),
    .col_o      (drain_col_s),
    .pass_o     (drain_pass_unused_s),
    .last_o     (drain_last_s)
  );

  // tile storage; pass 0 never reads it, so it needs no reset or clear
  always_ff @(posedge clk_i) begin
    if (acc_en_s) begin
      mem_q[acc_row_s][acc_col_s] <= fm_i;
    end
  end

  assign drain_raw_s = mem_q[drain_row_s][drain_col_s];

`ifdef OFMBUF_RELU_EN
  assign drain_word_s = drain_raw_s[DATA_W_p-1] ? {DATA_W_p{1'b0}} : drain_raw_s;
`else
  assign drain_word_s = drain_raw_s;
`endif

  // sequencer next state, pass-count capture and done pulse
  always_comb begin
    state_d = state_q;
    npass_d = npass_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_ACCUM;
          npass_d = (num_pass_i == {PASS_W_p{1'b0}}) ? PASS_W_p'(1) : num_pass_i;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (acc_en_s && acc_last_s) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_DRAIN: begin
        if (drain_en_s && drain_last_s) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // sequencer registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      npass_q <= {PASS_W_p{1'b0}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      npass_q <= npass_d;
      done_q  <= done_d;
    end
  end

  // state-qualified outputs; everything is zero outside the owning state
  always_comb begin
    busy_o      = 1'b0;
    fm_init_o   = {DATA_W_p{1'b0}};
    out_valid_o = 1'b0;
    out_data_o  = {DATA_W_p{1'b0}};
    out_last_o  = 1'b0;
    case (state_q)
      ST_ACCUM: begin
        busy_o = 1'b1;
        if (acc_pass_s != {PASS_W_p{1'b0}}) begin
          fm_init_o = mem_q[acc_row_s][acc_col_s];
        end else begin
          fm_init_o = {DATA_W_p{1'b0}};
        end
      end
      ST_DRAIN: begin
        busy_o      = 1'b1;
        out_valid_o = 1'b1;
        out_data_o  = drain_word_s;
        out_last_o  = drain_last_s;
      end
      ST_IDLE: begin
        busy_o = 1'b0;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

  assign done_o = done_q;
  assign row_o  = acc_row_s;
  assign col_o  = acc_col_s;
  assign pass_o = acc_pass_s;

endmodule : output_fm_buffer

// File: tb/tb_output_fm_buffer.sv
// -----------------------------------------------------------------------------
// tb_output_fm_buffer
// Randomized self-checking bench for output_fm_buffer on a non-square 3x2 tile.
// The bench plays the MAC stage: it keeps its own array of partial sums,
// derives the expected location from a flat element count, and compares every
// observable output on the falling edge.
// -----------------------------------------------------------------------------
module tb_output_fm_buffer;

  localparam int TR = 3;
  localparam int TC = 2;
  localparam int N  = TR * TC;
  localparam int DW = 32;
  localparam int PW = 8;

  logic                  clk;
  logic                  rst_n;
  logic                  start_i;
  logic [PW-1:0]         num_pass_i;
  logic                  busy_o;
  logic                  done_o;
  logic [$clog2(TR)-1:0] row_o;
  logic [$clog2(TC)-1:0] col_o;
  logic [PW-1:0]         pass_o;
  logic [DW-1:0]         fm_init_o;
  logic                  mac_valid_i;
  logic [DW-1:0]         fm_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [DW-1:0]         out_data_o;
  logic                  out_last_o;

  output_fm_buffer #(.Tr_p(TR), .Tc_p(TC), .DATA_W_p(DW), .PASS_W_p(PW)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .start_i     (start_i),
    .num_pass_i  (num_pass_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .row_o       (row_o),
    .col_o       (col_o),
    .pass_o      (pass_o),
    .fm_init_o   (fm_init_o),
    .mac_valid_i (mac_valid_i),
    .fm_i        (fm_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_last_o  (out_last_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] model [N];   // reference partial sums, flat row-major
  int            add_v [N];   // directed pass-0 addends
  int            add_later;   // directed addend for later passes

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] drained(input logic [DW-1:0] v);
`ifdef OFMBUF_RELU_EN
    if ($signed(v) < 0) return 32'd0;
`endif
    return v;
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"},  64'(busy_o),      64'd0);
    check_eq({tag, "_done"},  64'(done_o),      64'd0);
    check_eq({tag, "_row"},   64'(row_o),       64'd0);
    check_eq({tag, "_col"},   64'(col_o),       64'd0);
    check_eq({tag, "_pass"},  64'(pass_o),      64'd0);
    check_eq({tag, "_init"},  64'(fm_init_o),   64'd0);
    check_eq({tag, "_valid"}, 64'(out_valid_o), 64'd0);
    check_eq({tag, "_data"},  64'(out_data_o),  64'd0);
    check_eq({tag, "_last"},  64'(out_last_o),  64'd0);
  endtask

  // Runs one tile from the falling edge where start is to be driven (or, when
  // started=1, from the first ACCUM falling edge). rdy_mode: 0 always ready,
  // 1 pattern 1,0,0 repeating, 2 random. chain starts the next tile in the
  // done cycle.
  task automatic run_tile(input int np_in, input int rdy_mode, input bit rnd,
                          input bit started, input bit pulse_start,
                          input bit chain, input int chain_np);
    int            np, total, k, j, cyc, idx, ps, addend;
    logic [DW-1:0] exp_init, v;
    bit            mv, rdy;
    np    = (np_in == 0) ? 1 : np_in;
    total = np * N;
    if (!started) begin
      start_i    = 1'b1;
      num_pass_i = PW'(np_in);
      @(negedge clk);
      start_i    = 1'b0;
      num_pass_i = PW'($urandom);
    end
    k   = 0;
    cyc = 0;
    while (k < total && cyc < 20 * total + 20) begin
      idx      = k % N;
      ps       = k / N;
      exp_init = (ps == 0) ? 32'd0 : model[idx];
      check_eq("acc_busy",  64'(busy_o),      64'd1);
      check_eq("acc_valid", 64'(out_valid_o), 64'd0);
      check_eq("acc_row",   64'(row_o),       64'(idx / TC));
      check_eq("acc_col",   64'(col_o),       64'(idx % TC));
      check_eq("acc_pass",  64'(pass_o),      64'(ps));
      check_eq("acc_init",  64'(fm_init_o),   64'(exp_init));
      mv          = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      mac_valid_i = mv;
      out_ready_i = 1'($urandom_range(0, 1));
      start_i     = 1'($urandom_range(0, 1));
      if (mv) begin
        addend     = rnd ? int'($urandom) : ((ps == 0) ? add_v[idx] : add_later);
        v          = exp_init + DW'(addend);
        fm_i       = v;
        model[idx] = v;
        k++;
      end else begin
        fm_i = DW'($urandom);
      end
      cyc++;
      @(negedge clk);
    end
    if (k < total) check_eq("acc_budget", 64'(k), 64'(total));
    start_i = 1'b0;
    j   = 0;
    cyc = 0;
    while (j < N && cyc < 20 * N) begin
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready_i = rdy;
      mac_valid_i = 1'($urandom_range(0, 1));
      fm_i        = DW'($urandom);
      start_i     = pulse_start && (j == 1);
      check_eq("drn_valid", 64'(out_valid_o), 64'd1);
      check_eq("drn_data",  64'(out_data_o),  64'(drained(model[j])));
      check_eq("drn_last",  64'(out_last_o),  64'(j == N - 1));
      check_eq("drn_busy",  64'(busy_o),      64'd1);
      check_eq("drn_done",  64'(done_o),      64'd0);
      check_eq("drn_init",  64'(fm_init_o),   64'd0);
      if (rdy) j++;
      cyc++;
      @(negedge clk);
    end
    mac_valid_i = 1'b0;
    start_i     = 1'b0;
    check_eq("end_done",  64'(done_o),      64'd1);
    check_eq("end_busy",  64'(busy_o),      64'd0);
    check_eq("end_valid", 64'(out_valid_o), 64'd0);
    check_eq("end_data",  64'(out_data_o),  64'd0);
    if (chain) begin
      start_i    = 1'b1;
      num_pass_i = PW'(chain_np);
      @(negedge clk);
      start_i    = 1'b0;
      num_pass_i = PW'($urandom);
    end else begin
      @(negedge clk);
      check_eq("idle_done", 64'(done_o), 64'd0);
      check_eq("idle_busy", 64'(busy_o), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    start_i     = 1'b0;
    num_pass_i  = '0;
    mac_valid_i = 1'b0;
    fm_i        = '0;
    out_ready_i = 1'b0;
    add_later   = 0;
    #2;
    check_all_zero("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_rst");

    // single pass, fixed values 10,20,...
    for (int i = 0; i < N; i++) add_v[i] = 10 * (i + 1);
    run_tile(1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // two passes: pass0 1..N, pass1 init + 5
    for (int i = 0; i < N; i++) add_v[i] = i + 1;
    add_later = 5;
    run_tile(2, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // backpressure 1,0,0 with a start pulse during drain
    for (int i = 0; i < N; i++) add_v[i] = 100 + i;
    run_tile(1, 1, 1'b0, 1'b0, 1'b1, 1'b0, 0);

    // negative and zero values for the drain sign handling
    add_v[0] = -7; add_v[1] = 3; add_v[2] = -1; add_v[3] = 0; add_v[4] = -100; add_v[5] = 5;
    run_tile(1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // reset in the middle of accumulation
    start_i    = 1'b1;
    num_pass_i = PW'(1);
    @(negedge clk);
    start_i     = 1'b0;
    mac_valid_i = 1'b1;
    fm_i        = 32'd77;
    @(negedge clk);
    fm_i        = 32'd88;
    @(negedge clk);
    mac_valid_i = 1'b0;
    rst_n       = 1'b0;
    #1;
    check_all_zero("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("mid_rst_idle");
    run_tile(2, 2, 1'b1, 1'b0, 1'b0, 1'b0, 0);

    // num_pass 0 acts as a single pass
    run_tile(0, 2, 1'b1, 1'b0, 1'b0, 1'b0, 0);

    // back-to-back: start accepted in the done cycle
    run_tile(1, 2, 1'b1, 1'b0, 1'b1, 1'b1, 3);
    run_tile(3, 1, 1'b1, 1'b1, 1'b0, 1'b0, 0);

    // random tiles
    for (int t = 0; t < 6; t++) begin
      run_tile($urandom_range(0, 3), $urandom_range(0, 2), 1'b1, 1'b0,
               1'($urandom_range(0, 1)), 1'b0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_output_fm_buffer

// File: doc/output_fm_buffer.md
# output_fm_buffer

Output-tile partial-sum buffer and sequencer that sits directly downstream of the input-channel MAC stage. It holds one Tr×Tc output-feature-map tile and presents the running partial sum for the current (row, col) as `fm_init_o` to the MAC stage. It writes the MAC result back, repeating over `num_pass_i` input-channel passes. After the final pass it drains the tile row-major over a valid/ready stream.

## Interface
- `Tr_p`, default 4: tile rows, must be ≥ 2.
- `Tc_p`, default 4: tile columns, must be ≥ 2.
- `DATA_W_p`, default 32: data width, signed two's-complement fixed point.
- `PASS_W_p`, default 8: width of the pass count.

Ports (clock and reset first):
- `clk_i` in 1: single clock, all state on rising edge.
- `rst_n_i` in 1: asynchronous active-low reset.
- `start_i` in 1: begin a tile; sampled only in IDLE.
- `num_pass_i` in PASS_W_p: number of input-channel passes; sampled with `start_i`.
- `busy_o` out 1: high in ACCUM or DRAIN.
- `done_o` out 1: one-cycle pulse on final drain handshake.
- `row_o` out $clog2(Tr_p): current row, for the feeder and MAC stage.
- `col_o` out $clog2(Tc_p): current column.
- `pass_o` out PASS_W_p: current pass index.
- `fm_init_o` out DATA_W_p: partial sum for (row_o, col_o).
- `mac_valid_i` in 1: `fm_i` holds a valid MAC result for the current location.
- `fm_i` in DATA_W_p: MAC stage output, equal to the sum of products plus `fm_init_o`.
- `out_valid_o` out 1: drain data valid.
- `out_ready_i` in 1: downstream accepts.
- `out_data_o` out DATA_W_p: drained element.
- `out_last_o` out 1: final element of tile.

## Operation
- FSM has three states: IDLE, ACCUM, DRAIN.
- **IDLE → ACCUM** on `start_i`:
  - Latch `num_pass_i`; a value of 0 is treated as 1.
  - Clear the row, col and pass counters.
- **ACCUM**, when `mac_valid_i`=1:
  - Write `fm_i` to mem[row][col].
  - Advance col. On col wrap advance row. On row wrap advance pass.
  - On the last col, last row and last pass, go to DRAIN with the drain counter cleared.
- **ACCUM**, when `mac_valid_i`=0: hold.
- `fm_init_o`:
  - Zero whenever pass = 0, so memory is never cleared and needs no reset.
  - Otherwise a combinational read of mem[row_o][col_o].
  - Zero outside ACCUM.
- **DRAIN**:
  - `out_valid_o`=1 and `out_data_o` = mem[drain index], row-major order.
  - The index advances only on `out_valid_o && out_ready_i`.
  - `out_last_o`=1 at index Tr_p·Tc_p−1.
  - On the last handshake: go to IDLE and pulse `done_o`.
  - Data and last are held stable while valid is high and ready is low.
- Inputs ignored outside their state:
  - `start_i` outside IDLE.
  - `mac_valid_i` outside ACCUM.
- No arithmetic in this block; the addition happens in the MAC stage. Width is DATA_W_p throughout.

## Timing
- Reset values: IDLE, all counters 0, and every output 0 (including `fm_init_o`, `out_data_o` and `done_o`). Memory contents are undefined after reset.
- `start_i` is seen at edge k, so `busy_o`=1 and ACCUM begins in cycle k+1.
- The `fm_init_o` → `fm_i` path is combinational through the MAC stage, so one location is accepted per `mac_valid_i` cycle.
- Minimum tile latency: num_pass·Tr_p·Tc_p ACCUM cycles plus Tr_p·Tc_p DRAIN cycles.
- `done_o` is high in the cycle after the final handshake, together with `busy_o`=0. A `start_i` in that same cycle is accepted.
- Reset asserted mid-ACCUM or mid-DRAIN: return to IDLE immediately and drop all outputs to 0. The partial tile is discarded.

## Configuration
- `OFMBUF_RELU_EN` defined: `out_data_o` is forced to 0 when the stored value's MSB is 1. Memory and `fm_init_o` are unaffected.
- Not defined: raw stored values are drained.

## Structure
- Shared package `cnn_pkg` holds:
  - the state enum `ofmbuf_state_e`;
  - the default data width constant `CNN_DATA_W`.
- One natural sub-module, `tile_counter`: a row/col/pass nested wrap counter with an enable input and a last flag. It is reused for both ACCUM and DRAIN indexing.

## Test plan
- **Single pass:** Tr=Tc=2, num_pass=1, `fm_i`=10,20,30,40 → `fm_init_o` 0 every cycle; drain gives 10,20,30,40 with last on 40; `done_o` pulses once.
- **Two passes:** pass0 `fm_i`=1,2,3,4; pass1 drives `fm_i` = `fm_init_o`+5 → pass1 `fm_init_o` reads 1,2,3,4; drain gives 6,7,8,9.
- **Backpressure:** `out_ready_i` toggled 1,0,0,1,… → each element is emitted exactly once, held stable while stalled, order preserved.
- **ReLU** (`OFMBUF_RELU_EN`): stored −7,3,−1,0 → drain gives 0,3,0,0. Without the macro → −7,3,−1,0.
- **Reset mid-ACCUM:** `rst_n_i` low after 2 writes → IDLE on the next sample, all outputs 0. A new tile then runs cleanly with pass0 `fm_init_o`=0.
- **Control edge cases:**
  - `start_i` pulsed during DRAIN → ignored.
  - num_pass=0 → behaves as 1.
  - `mac_valid_i` gaps → counters hold.
